// File: rtl/csb_req_buffer.sv
// rtl/csb_req_buffer.sv - CSB request FIFO with credit-gated issue and registered response path
// Sits between periph_to_csb and the NVDLA CSB port.
module csb_req_buffer #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_addr,
  input  logic [31:0] s_wdat,
  input  logic        s_write,
  input  logic        s_nposted,
  output logic        s_rvalid,
  output logic [31:0] s_rdata,
  output logic        s_wr_complete,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_addr,
  output logic [31:0] m_wdat,
  output logic        m_write,
  output logic        m_nposted,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic        m_wr_complete,
  output logic [3:0]  outstanding_o,
  output logic        resp_err_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [3:0]  MAX_OUT  = 4'(MAX_OUTSTANDING);

  logic [15:0]   addr_mem    [DEPTH];
  logic [31:0]   wdat_mem    [DEPTH];
  logic          write_mem   [DEPTH];
  logic          nposted_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    outstanding;
  logic          push;
  logic          pop;
  logic          needs_resp;
  logic [4:0]    out_up;
  logic [4:0]    out_dec;
  logic          underflow;

  assign m_addr     = addr_mem[rd_ptr];
  assign m_wdat     = wdat_mem[rd_ptr];
  assign m_write    = write_mem[rd_ptr];
  assign m_nposted  = nposted_mem[rd_ptr];
  assign needs_resp = !m_write || m_nposted;

  // A response-bearing head with no credit blocks everything behind it.
  assign s_ready = (count != FULL_CNT);
  assign m_valid = (count != '0) && !(needs_resp && (outstanding == MAX_OUT));
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  assign out_up    = {1'b0, outstanding} + 5'(pop && needs_resp);
  assign out_dec   = 5'(m_rvalid) + 5'(m_wr_complete);
  assign underflow = out_dec > out_up;

  assign outstanding_o = outstanding;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i]    <= '0;
        wdat_mem[i]    <= '0;
        write_mem[i]   <= 1'b0;
        nposted_mem[i] <= 1'b0;
      end
    end else if (push) begin
      addr_mem[wr_ptr]    <= s_addr;
      wdat_mem[wr_ptr]    <= s_wdat;
      write_mem[wr_ptr]   <= s_write;
      nposted_mem[wr_ptr] <= s_nposted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Spurious responses are still forwarded; the counter clamps at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      resp_err_o  <= 1'b0;
    end else begin
      outstanding <= underflow ? 4'd0 : 4'(out_up - out_dec);
      if (underflow) resp_err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_rvalid      <= 1'b0;
      s_wr_complete <= 1'b0;
      s_rdata       <= '0;
    end else begin
      s_rvalid      <= m_rvalid;
      s_wr_complete <= m_wr_complete;
      if (m_rvalid) s_rdata <= m_rdata;
    end
  end

endmodule

// File: tb/tb_csb_req_buffer.sv
// tb/tb_csb_req_buffer.sv - directed and randomized bench for csb_req_buffer with a queue-based reference model
module tb_csb_req_buffer;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready;
  logic [15:0] s_addr;
  logic [31:0] s_wdat;
  logic        s_write, s_nposted;
  logic        s_rvalid, s_wr_complete;
  logic [31:0] s_rdata;
  logic        m_valid, m_ready;
  logic [15:0] m_addr;
  logic [31:0] m_wdat;
  logic        m_write, m_nposted;
  logic        m_rvalid, m_wr_complete;
  logic [31:0] m_rdata;
  logic [3:0]  outstanding_o;
  logic        resp_err_o;

  csb_req_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdat(s_wdat),
    .s_write(s_write), .s_nposted(s_nposted),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_wr_complete(s_wr_complete),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdat(m_wdat),
    .m_write(m_write), .m_nposted(m_nposted),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_wr_complete(m_wr_complete),
    .outstanding_o(outstanding_o), .resp_err_o(resp_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
    logic        w;
    logic        np;
  } ent_t;

  ent_t        q[$];
  int          m_out;
  bit          m_err;
  bit          m_rv, m_wc;
  logic [31:0] m_rd;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ent_needs_resp(input ent_t e);
    return !e.w || e.np;
  endfunction

  function automatic bit model_mvalid();
    if (q.size() == 0) return 1'b0;
    return !(ent_needs_resp(q[0]) && m_out == MAXO);
  endfunction

  task automatic model_reset();
    q.delete();
    m_out = 0; m_err = 0; m_rv = 0; m_wc = 0; m_rd = '0;
  endtask

  task automatic step(input bit v, input logic [15:0] a, input logic [31:0] d, input bit w,
                      input bit np, input bit mr, input bit rv, input logic [31:0] rd, input bit wc);
    bit   exp_mv, exp_sr;
    ent_t e;
    int   nxt;
    s_valid = v; s_addr = a; s_wdat = d; s_write = w; s_nposted = np;
    m_ready = mr; m_rvalid = rv; m_rdata = rd; m_wr_complete = wc;
    exp_mv = model_mvalid();
    exp_sr = (q.size() != DEPTH);
    check("s_ready", 64'(s_ready), 64'(exp_sr));
    check("m_valid", 64'(m_valid), 64'(exp_mv));
    check("outstanding", 64'(outstanding_o), 64'(m_out));
    check("resp_err", 64'(resp_err_o), 64'(m_err));
    check("s_rvalid", 64'(s_rvalid), 64'(m_rv));
    check("s_wr_complete", 64'(s_wr_complete), 64'(m_wc));
    check("s_rdata", 64'(s_rdata), 64'(m_rd));
    if (q.size() != 0) check("m_head", {m_addr, m_wdat, m_write, m_nposted}, 64'(q[0]));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      nxt = m_out - int'(rv) - int'(wc);
      if (exp_mv && mr) begin
        e = q.pop_front();
        if (ent_needs_resp(e)) nxt++;
      end
      if (v && exp_sr) q.push_back('{a: a, d: d, w: w, np: np});
      if (nxt < 0) begin
        m_err = 1;
        nxt = 0;
      end
      m_out = nxt;
      m_rv = rv;
      m_wc = wc;
      if (rv) m_rd = rd;
    end
    #1;
  endtask

  task automatic idle(input bit mr);
    step(0, 16'h0, 32'h0, 0, 0, mr, 0, 32'h0, 0);
  endtask

  task automatic resp(input bit rv, input logic [31:0] rd, input bit wc);
    step(0, 16'h0, 32'h0, 0, 0, 1, rv, rd, wc);
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 0; s_addr = '0; s_wdat = '0; s_write = 0; s_nposted = 0;
    m_ready = 0; m_rvalid = 0; m_rdata = '0; m_wr_complete = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_m_valid", 64'(m_valid), 64'd0);

    // Posted writes
    for (int i = 0; i < 4; i++) step(1, 16'h0010 + 16'(i), $urandom, 1, 0, 1, 0, 32'h0, 0);
    repeat (2) idle(1);
    check("pw_out", 64'(outstanding_o), 64'd0);

    // Backpressure and full
    for (int i = 0; i < 5; i++) step(1, 16'h0020 + 16'(i), $urandom, 1, 0, 0, 0, 32'h0, 0);
    check("bp_full", 64'(s_ready), 64'd0);
    step(1, 16'h0024, 32'h2424, 1, 0, 1, 0, 32'h0, 0);
    check("bp_after_pop", 64'(s_ready), 64'd1);
    step(1, 16'h0024, 32'h2424, 1, 0, 0, 0, 32'h0, 0);
    repeat (5) idle(1);

    // Credit stall
    step(1, 16'h0100, 32'h0, 0, 0, 1, 0, 32'h0, 0);
    step(1, 16'h0104, 32'h0, 0, 0, 1, 0, 32'h0, 0);
    step(1, 16'h0108, 32'h0, 0, 0, 1, 0, 32'h0, 0);
    check("cs_out2", 64'(outstanding_o), 64'd2);
    check("cs_gated", 64'(m_valid), 64'd0);
    resp(1, 32'hDEADBEEF, 0);
    check("cs_rvalid", 64'(s_rvalid), 64'd1);
    check("cs_rdata", 64'(s_rdata), 64'hDEADBEEF);
    check("cs_issue3", 64'(m_valid), 64'd1);
    check("cs_addr3", 64'(m_addr), 64'h0108);
    idle(1);
    resp(1, 32'h11111111, 0);
    resp(1, 32'h22222222, 0);

    // Head-of-line blocking
    step(1, 16'h0110, 32'h0, 0, 0, 1, 0, 32'h0, 0);
    step(1, 16'h0114, 32'h0, 0, 0, 1, 0, 32'h0, 0);
    step(1, 16'h0200, 32'h0, 0, 0, 1, 0, 32'h0, 0);
    step(1, 16'h0204, 32'h5555, 1, 0, 1, 0, 32'h0, 0);
    check("hol_gated", 64'(m_valid), 64'd0);
    idle(1);
    check("hol_still", 64'(m_valid), 64'd0);
    resp(1, 32'h33333333, 0);
    check("hol_read_first", 64'(m_addr), 64'h0200);
    idle(1);
    check("hol_write_next", 64'({m_valid, m_write, m_addr}), {2'b11, 16'h0204});
    idle(1);
    resp(1, 32'h44444444, 0);
    resp(1, 32'h55555555, 0);

    // Simultaneous responses
    step(1, 16'h0300, 32'h0, 0, 0, 1, 0, 32'h0, 0);
    step(1, 16'h0304, 32'h6666, 1, 1, 1, 0, 32'h0, 0);
    idle(1);
    check("sim_out2", 64'(outstanding_o), 64'd2);
    resp(1, 32'hCAFEF00D, 1);
    check("sim_out0", 64'(outstanding_o), 64'd0);
    check("sim_pulses", 64'({s_rvalid, s_wr_complete}), 64'b11);

    // Spurious completion, then reset mid-operation
    resp(0, 32'h0, 1);
    check("err_fwd", 64'(s_wr_complete), 64'd1);
    check("err_set", 64'(resp_err_o), 64'd1);
    idle(0);
    check("err_hold", 64'(resp_err_o), 64'd1);
    step(1, 16'h0400, 32'h0, 1, 0, 0, 0, 32'h0, 0);
    step(1, 16'h0401, 32'h0, 1, 0, 0, 0, 32'h0, 0);
    rst = 1'b1;
    step(0, 16'h0, 32'h0, 0, 0, 0, 1, 32'h77777777, 0);
    rst = 1'b0;
    check("rst2_state", 64'({m_valid, s_ready, outstanding_o, resp_err_o, s_rvalid}), 64'b0_1_0000_0_0);
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit rv, wc;
      rv = (m_out > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0);
      wc = (m_out > 1 || (m_out > 0 && !rv)) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0);
      rst = ($urandom_range(0, 120) == 0);
      step($urandom_range(0, 1), 16'($urandom), $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 3) != 0, rv, $urandom, wc);
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csb_req_buffer.md
Name: csb_req_buffer

Overview:
- CSB request/response buffering stage placed directly downstream of periph_to_csb, in front of the NVDLA core CSB port.
- Decouples the HWPE peripheral from CSB backpressure with a request FIFO.
- Limits outstanding response-bearing transactions with a credit counter.
- Registers the read-data and write-completion response paths back to periph_to_csb.

Parameters:
- DEPTH, 4: request FIFO entries; power of 2, ≥2.
- MAX_OUTSTANDING, 2: maximum in-flight reads plus non-posted writes; 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  request from periph_to_csb.
- s_ready  out  1  request accepted when s_valid && s_ready.
- s_addr  in  16  CSB word address.
- s_wdat  in  32  write data.
- s_write  in  1  1 = write, 0 = read.
- s_nposted  in  1  write expects completion (ignored for reads).
- s_rvalid  out  1  read data valid (single-cycle pulse).
- s_rdata  out  32  read data.
- s_wr_complete  out  1  non-posted write completion (single-cycle pulse).
- m_valid  out  1  request to NVDLA CSB.
- m_ready  in  1  NVDLA accepts request.
- m_addr  out  16  FIFO head address.
- m_wdat  out  32  FIFO head write data.
- m_write  out  1  FIFO head write flag.
- m_nposted  out  1  FIFO head nposted flag.
- m_rvalid  in  1  read response from NVDLA.
- m_rdata  in  32  read response data.
- m_wr_complete  in  1  write completion from NVDLA.
- outstanding_o  out  4  current in-flight count.
- resp_err_o  out  1  sticky flag: a response arrived with nothing outstanding.

Behaviour:
- Reset: pointers = 0, count = 0, outstanding = 0. All outputs 0 except s_ready = 1. resp_err_o cleared.
- Reset mid-operation discards FIFO contents and in-flight tracking; responses arriving in the reset cycle are dropped.

FIFO:
- Entry = {addr, wdat, write, nposted}.
- Push = s_valid && s_ready; s_ready = (count != DEPTH).
- No bypass: an entry accepted in cycle N is first visible on m_* in cycle N+1.
- Push and pop in the same cycle: count unchanged; both pointers advance, wrapping modulo DEPTH.
- When full, s_ready = 0, including in a cycle where a pop occurs. s_ready rises the cycle after the pop.
- m_addr, m_wdat, m_write, m_nposted always reflect the head entry; they are don't-care when m_valid = 0.

Credit gating:
- needs_resp = !head.write || head.nposted.
- m_valid = (count != 0) && !(needs_resp && outstanding == MAX_OUTSTANDING).
- Posted writes are never gated.
- Gated head blocks the queue: strict in-order issue, no reordering.
- Pop = m_valid && m_ready. m_valid does not drop while waiting on m_ready except on reset.

Outstanding counter:
- +1 on pop when needs_resp.
- -1 for each of m_rvalid and m_wr_complete asserted; both in one cycle gives -2.
- Issue and response in the same cycle net to the sum of the above.
- If a response would drive outstanding below 0:
  - the response is still forwarded;
  - outstanding saturates at 0;
  - resp_err_o sets and holds until rst.

Response path:
- s_rvalid, s_wr_complete = m_rvalid, m_wr_complete delayed 1 cycle.
- s_rdata loaded only when m_rvalid = 1; otherwise holds its last value.
- Simultaneous m_rvalid and m_wr_complete produce both upstream pulses in the same following cycle.

Latency:
- Request: 1 cycle minimum, s accept → m_valid.
- Response: 1 cycle.

Test Plan:
- Posted writes: 4 back-to-back writes (s_nposted = 0, addr 0x0010..0x0013) with m_ready = 1 → m_valid from cycle 1; 4 pops in order; outstanding_o stays 0; no upstream pulses.
- Backpressure/full: m_ready = 0 while pushing 5 writes (DEPTH = 4) → s_ready = 0 after 4th accept; 5th held. Raise m_ready for 1 cycle → s_ready = 1 the next cycle; 5th accepted; order preserved.
- Credit stall: 3 reads to 0x0100/0x0104/0x0108, NVDLA holds responses → 2 issued, outstanding_o = 2, third m_valid = 0. m_rvalid with m_rdata = 0xDEADBEEF → s_rvalid one cycle later with s_rdata = 0xDEADBEEF; third read issues the following cycle.
- Head-of-line blocking: with outstanding = 2, FIFO holds read then posted write → both stall until a credit returns; issued read-then-write.
- Simultaneous responses: outstanding = 2 (1 read, 1 non-posted write), m_rvalid and m_wr_complete in the same cycle → outstanding_o = 0 next cycle; s_rvalid and s_wr_complete both pulse in the same cycle.
- Error and reset: m_wr_complete with outstanding = 0 → s_wr_complete pulses, resp_err_o = 1 and stays 1. Push 2 entries, assert rst 1 cycle → m_valid = 0, s_ready = 1, outstanding_o = 0, resp_err_o = 0.
